// File: rtl/touchpad_emulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// touchpad_emulator : SPI slave model of a resistive-touch ADC returning 12-bit
//                     X/Y/Z samples. Optional macro TOUCH_EMU_NOISE_EN adds dither.
// Revision 1.0
// ---------------------------------------------------------------------------
module touchpad_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CLKS   = 1
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        touch_clk,
  input  logic        touch_csb,
  input  logic        spi_din,
  input  logic [11:0] tp_x,
  input  logic [11:0] tp_y,
  input  logic [11:0] tp_z,
  input  logic        pen_down,
  output logic        spi_dout,
  output logic        touch_busy,
  output logic [7:0]  last_cmd,
  output logic        cmd_valid,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    BUSY       = 3'd3,
    DATA       = 3'd4,
    TAIL       = 3'd5
  } state_t;

  localparam logic [1:0] BUSY_LAST = 2'(BUSY_CLKS);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   clk_prev;
  logic                   clk_rise;
  logic                   clk_fall;
  logic                   csb_s;
  logic                   din_s;

  state_t      st;
  logic [7:0]  cmd_shift;
  logic [7:0]  cmd_next;
  logic [3:0]  bit_cnt;
  logic [1:0]  busy_cnt;
  logic [3:0]  data_idx;
  logic [3:0]  data_nidx;
  logic [11:0] sample;
  logic [11:0] raw_sample;
  logic [11:0] sample_next;

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      clk_sync <= '0;
      csb_sync <= '1;
      din_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], touch_clk};
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], touch_csb};
      din_sync <= {din_sync[SYNC_STAGES-2:0], spi_din};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_rise  =  clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign clk_fall  = ~clk_sync[SYNC_STAGES-1] &  clk_prev;
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign cmd_next  = {cmd_shift[6:0], din_s};
  assign data_nidx = data_idx - 4'd1;
  assign state     = st;

  // Channel decode uses the byte being completed this cycle.
  always_comb begin
    raw_sample = 12'h000;
    if (pen_down) begin
      case (cmd_next[6:4])
        3'b101:  raw_sample = tp_x;
        3'b001:  raw_sample = tp_y;
        3'b011:  raw_sample = tp_z;
        default: raw_sample = 12'h000;
      endcase
    end
  end

`ifdef TOUCH_EMU_NOISE_EN
  logic [15:0] lfsr;
  logic [13:0] noisy;
  logic        raw_known;

  assign raw_known = pen_down && ((cmd_next[6:4] == 3'b101) ||
                                  (cmd_next[6:4] == 3'b001) ||
                                  (cmd_next[6:4] == 3'b011));
  assign noisy = {2'b00, raw_sample} + {{11{lfsr[2]}}, lfsr[2:0]};

  // Bit 13 flags an underflow below zero, bit 12 an overflow past 4095.
  always_comb begin
    sample_next = 12'h000;
    if (raw_known) begin
      if (noisy[13])      sample_next = 12'h000;
      else if (noisy[12]) sample_next = 12'hFFF;
      else                sample_next = noisy[11:0];
    end
  end

  always_ff @(posedge cclk) begin
    if (!rstb)          lfsr <= 16'hACE1;
    else if (cmd_valid) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign sample_next = raw_sample;
`endif

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      st         <= IDLE;
      spi_dout   <= 1'b0;
      touch_busy <= 1'b0;
      last_cmd   <= 8'h00;
      cmd_valid  <= 1'b0;
      cmd_shift  <= 8'h00;
      bit_cnt    <= 4'd0;
      busy_cnt   <= 2'd0;
      data_idx   <= 4'd0;
      sample     <= 12'h000;
    end else begin
      cmd_valid <= 1'b0;
      if (csb_s) begin
        // Deselect aborts whatever is in flight; clock edges are ignored.
        st         <= IDLE;
        spi_dout   <= 1'b0;
        touch_busy <= 1'b0;
        bit_cnt    <= 4'd0;
        busy_cnt   <= 2'd0;
        data_idx   <= 4'd0;
      end else begin
        case (st)
          IDLE: st <= WAIT_START;
          WAIT_START: begin
            if (clk_rise && din_s) begin
              st        <= CMD;
              cmd_shift <= 8'h01;
              bit_cnt   <= 4'd1;
            end
          end
          CMD: begin
            if (clk_rise) begin
              cmd_shift <= cmd_next;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                last_cmd  <= cmd_next;
                cmd_valid <= 1'b1;
                sample    <= sample_next;
                busy_cnt  <= 2'd0;
                st        <= BUSY;
              end
            end
          end
          BUSY: begin
            if (clk_fall) begin
              if (busy_cnt == BUSY_LAST) begin
                touch_busy <= 1'b0;
                spi_dout   <= sample[11];
                data_idx   <= 4'd11;
                st         <= DATA;
              end else begin
                touch_busy <= 1'b1;
                busy_cnt   <= busy_cnt + 2'd1;
              end
            end
          end
          DATA: begin
            if (clk_fall) begin
              if (data_idx == 4'd0) begin
                spi_dout <= 1'b0;
                st       <= TAIL;
              end else begin
                spi_dout <= sample[data_nidx];
                data_idx <= data_nidx;
              end
            end
          end
          TAIL: begin
            spi_dout <= 1'b0;
            if (clk_rise && din_s) begin
              st        <= CMD;
              cmd_shift <= 8'h01;
              bit_cnt   <= 4'd1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_touchpad_emulator.sv
`default_nettype none
// tb_touchpad_emulator : directed SPI-master bench for touchpad_emulator.
module tb_touchpad_emulator;

  localparam int HALF = 6;

  logic        cclk = 1'b0;
  logic        rstb;
  logic        touch_clk;
  logic        touch_csb;
  logic        spi_din;
  logic [11:0] tp_x, tp_y, tp_z;
  logic        pen_down;
  logic        spi_dout;
  logic        touch_busy;
  logic [7:0]  last_cmd;
  logic        cmd_valid;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;

  touchpad_emulator dut (
    .cclk(cclk), .rstb(rstb), .touch_clk(touch_clk), .touch_csb(touch_csb),
    .spi_din(spi_din), .tp_x(tp_x), .tp_y(tp_y), .tp_z(tp_z), .pen_down(pen_down),
    .spi_dout(spi_dout), .touch_busy(touch_busy), .last_cmd(last_cmd),
    .cmd_valid(cmd_valid), .state(state)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) if (cmd_valid) valid_seen++;

  typedef struct {
    logic [7:0]  cmd;
    int          zeros;
    logic        pen;
    logic [11:0] x, y, z;
    logic [11:0] exp_data;
    int          exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge cclk);
  endtask

  // One SCLK period; master samples dout/busy just before the rising edge.
  task automatic clk_bit(input logic d, output logic dout_s, output logic busy_s);
    spi_din = d;
    half();
    dout_s = spi_dout;
    busy_s = touch_busy;
    touch_clk = 1'b1;
    half();
    touch_clk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int zeros,
                       output logic [11:0] data, output int busy_hi, output int valids,
                       output logic [2:0] end_state, output logic end_dout);
    logic [7:0] c;
    logic       d, ds, bs;
    int         v0;
    c = cmd;
    data = 12'h000;
    busy_hi = 0;
    v0 = valid_seen;
    touch_csb = 1'b0;
    half(); half();
    for (int k = 1; k <= zeros + 24; k++) begin
      d = (k > zeros && k <= zeros + 8) ? c[7 - (k - zeros - 1)] : 1'b0;
      clk_bit(d, ds, bs);
      if (k >= zeros + 10 && k <= zeros + 21) data = {data[10:0], ds};
      if (bs) busy_hi++;
    end
    half();
    end_state = state;
    end_dout  = spi_dout;
    touch_csb = 1'b1;
    spi_din   = 1'b0;
    half();
    valids = valid_seen - v0;
  endtask

  initial begin
    logic [11:0] data;
    int          busy_hi, valids, v0;
    logic [2:0]  es;
    logic        ed, ds, bs;
    logic [7:0]  abort_cmd;

    vecs[0] = '{8'hD3, 0, 1'b1, 12'hA5C, 12'h123, 12'h7FF, 12'hA5C, 1};
    vecs[1] = '{8'h93, 0, 1'b1, 12'hA5C, 12'h123, 12'h7FF, 12'h123, 1};
    vecs[2] = '{8'hB3, 0, 1'b1, 12'hA5C, 12'h123, 12'h7FF, 12'h7FF, 1};
    vecs[3] = '{8'hD3, 3, 1'b1, 12'hA5C, 12'h123, 12'h7FF, 12'hA5C, 1};
    vecs[4] = '{8'hD3, 0, 1'b0, 12'hFFF, 12'h123, 12'h7FF, 12'h000, 1};
    vecs[5] = '{8'hE3, 0, 1'b1, 12'hFFF, 12'h123, 12'h7FF, 12'h000, 1};
    vecs[6] = '{8'h9F, 1, 1'b1, 12'h5A5, 12'h3C3, 12'h001, 12'h3C3, 1};

    rstb = 1'b0; touch_clk = 1'b0; touch_csb = 1'b1; spi_din = 1'b0;
    tp_x = 12'h0; tp_y = 12'h0; tp_z = 12'h0; pen_down = 1'b1;
    repeat (4) @(negedge cclk);
    chk("reset_dout", spi_dout, 1'b0);
    chk("reset_busy", touch_busy, 1'b0);
    chk("reset_last_cmd", last_cmd, 8'h00);
    chk("reset_cmd_valid", cmd_valid, 1'b0);
    chk("reset_state", state, 3'd0);
    rstb = 1'b1;
    half();
    chk("idle_csb_high", state, 3'd0);

    for (int i = 0; i < 7; i++) begin
      tp_x = vecs[i].x; tp_y = vecs[i].y; tp_z = vecs[i].z; pen_down = vecs[i].pen;
      frame(vecs[i].cmd, vecs[i].zeros, data, busy_hi, valids, es, ed);
`ifdef TOUCH_EMU_NOISE_EN
      if (vecs[i].exp_data == 12'h000)
        chk_range($sformatf("v%0d_data", i), int'(data), 0, 3);
      else
        chk_range($sformatf("v%0d_data", i), int'(data),
                  (int'(vecs[i].exp_data) >= 4) ? int'(vecs[i].exp_data) - 4 : 0,
                  (int'(vecs[i].exp_data) <= 4092) ? int'(vecs[i].exp_data) + 3 : 4095);
`else
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
`endif
      chk($sformatf("v%0d_busy_periods", i), busy_hi, vecs[i].exp_busy);
      chk($sformatf("v%0d_cmd_valid_pulses", i), valids, 1);
      chk($sformatf("v%0d_last_cmd", i), last_cmd, vecs[i].cmd);
      chk($sformatf("v%0d_tail_state", i), es, 3'd5);
      chk($sformatf("v%0d_tail_dout", i), ed, 1'b0);
      chk($sformatf("v%0d_idle_after_csb", i), state, 3'd0);
      chk($sformatf("v%0d_dout_csb_high", i), spi_dout, 1'b0);
    end

    // Aborted command: five bits of 8'h93, then deselect.
    abort_cmd = 8'h93;
    tp_x = 12'hA5C; tp_y = 12'h123; tp_z = 12'h7FF; pen_down = 1'b1;
    v0 = valid_seen;
    touch_csb = 1'b0;
    half(); half();
    for (int k = 0; k < 5; k++) clk_bit(abort_cmd[7 - k], ds, bs);
    touch_csb = 1'b1;
    half();
    chk("abort_state", state, 3'd0);
    chk("abort_dout", spi_dout, 1'b0);
    for (int k = 0; k < 3; k++) clk_bit(1'b1, ds, bs);
    chk("abort_dout_clk_csb_high", ds, 1'b0);
    chk("abort_no_cmd_valid", valid_seen - v0, 0);
    chk("abort_last_cmd_kept", last_cmd, vecs[6].cmd);
    frame(8'h93, 0, data, busy_hi, valids, es, ed);
`ifdef TOUCH_EMU_NOISE_EN
    chk_range("after_abort_data", int'(data), 12'h123 - 4, 12'h123 + 3);
`else
    chk("after_abort_data", data, 12'h123);
`endif
    chk("after_abort_valid", valids, 1);
    chk("after_abort_last_cmd", last_cmd, 8'h93);

`ifdef TOUCH_EMU_NOISE_EN
    tp_x = 12'h000;
    for (int n = 0; n < 64; n++) begin
      frame(8'hD3, 0, data, busy_hi, valids, es, ed);
      chk_range("noise_low", int'(data), 0, 3);
    end
    tp_x = 12'hFFF;
    for (int n = 0; n < 64; n++) begin
      frame(8'hD3, 0, data, busy_hi, valids, es, ed);
      chk_range("noise_high", int'(data), 4091, 4095);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
